result_stream_reader: RTL and testbench
=======================================

# result_stream_reader

Downstream readout stage for the matrix multiplier. Once the multiplier signals completion, this block walks the result RAM two entries per cycle through its dual read ports and buffers the words in a small FIFO. It streams the words out in ascending address order over a valid/ready interface, keeps a running checksum and compares it against the multiplier's matrix sum.

## Interface
- ADDR_WIDTH, 7: result RAM address width.
- RESULT_WIDTH, 24: result word width.
- NUM_ENTRIES, 128: entries to read. Must be even and ≤ 2**ADDR_WIDTH.
- FIFO_DEPTH, 4: output buffer depth. Must be a power of 2 and ≥ 4.

- CLOCK_50  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse, driven from the multiplier's end_operation; ignored unless IDLE.
- rd_addrA  output  ADDR_WIDTH  result RAM port A read address.
- rd_addrB  output  ADDR_WIDTH  result RAM port B read address.
- rd_dataA  input  RESULT_WIDTH  port A data; valid 1 cycle after address (registered read).
- rd_dataB  input  RESULT_WIDTH  port B data; valid 1 cycle after address.
- matrix_sum  input  RESULT_WIDTH  multiplier's final sum; stable from start until done.
- out_data  output  RESULT_WIDTH  streamed result word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse once the last word is accepted and the compare is finished.
- sum_match  output  1  compare result; updated on the done cycle and held until the next start.

## Operation
- FSM states: IDLE, READ, DRAIN, CHECK.
- IDLE → READ on start. Entering READ clears the address counter, checksum and sum_match.
- READ: issue a pair (rd_addrA = 2k, rd_addrB = 2k+1) only when FIFO free slots minus in-flight words ≥ 2. The FIFO therefore never overflows, regardless of out_ready.
- READ → DRAIN in the cycle after the last pair (NUM_ENTRIES−2, NUM_ENTRIES−1) is issued.
- Read data arrives one cycle after issue. Both words are pushed in the same cycle, A before B, so output order is strictly ascending address.
- DRAIN → CHECK when the FIFO is empty and nothing is in flight.
- CHECK → IDLE after one cycle.
  - done pulses in the CHECK cycle.
  - sum_match = (checksum == matrix_sum), registered on that cycle.
- Checksum: RESULT_WIDTH-bit sum modulo 2**RESULT_WIDTH, updated on each accepted output word (not on push).
- out_data, out_valid: driven from the FIFO head. out_data holds while out_valid && !out_ready.
- rd_addrA/B hold their last value when no pair is issued; 0 in IDLE.
- start while not IDLE: ignored, no restart.
- Reset mid-operation: everything returns to reset values immediately. Buffered and in-flight words are discarded, and no done pulse is produced.

## Timing
- Reset values:
  - state IDLE, FIFO empty, counters 0, checksum 0.
  - rd_addrA = 0, rd_addrB = 0, out_data = 0.
  - out_valid = 0, busy = 0, done = 0, sum_match = 0.
- Latency: start at cycle 0 → first pair issued cycle 1 → first out_valid cycle 3 (1-cycle RAM read, 1-cycle FIFO write-to-read).
- Throughput: the RAM side supplies 2 words/cycle; sustained output is 1 word/cycle with out_ready held high.
- With out_ready held high, done occurs 3 + NUM_ENTRIES + 1 cycles after start (±1 for the FIFO pipeline; the bench pins the exact value).
- out_valid never deasserts before the word is accepted.

## Structure
- Package result_stream_pkg:
  - state_t enum (IDLE, READ, DRAIN, CHECK).
  - default width constants.
  - function for FIFO free-slot computation.
- Sub-module result_fifo:
  - dual-push (2 words/cycle), single-pop, FIFO_DEPTH entries, wrap-around pointers.
  - count output; no overflow protection inside (the parent guarantees it).
- Top: FSM, address counter, in-flight tracking, checksum and compare.

## Test plan
- RAM model holds mem[i] = i+1, matrix_sum = 8256, out_ready = 1, start pulse → 128 words 1..128 in order, one per cycle; done once; sum_match = 1.
- Same setup, matrix_sum = 8255 → identical stream; sum_match = 0 at done.
- Random out_ready at 30% → stream still 1..128 with no drops or duplicates; out_data stable while stalled; reads stall with FIFO count never above FIFO_DEPTH.
- mem[i] = 24'hFFFFFF for all i, matrix_sum = 24'hFFFF80 (128·(2^24−1) mod 2^24) → sum_match = 1, confirming wrap-around.
- reset asserted after 40 words accepted → outputs go to reset values asynchronously with no done pulse; a new start then streams from address 0 again.
- start pulsed again during READ → ignored; exactly 128 words and one done pulse.

Source files
------------

// File: rtl/result_stream_pkg.sv
// Shared types, default widths and FIFO occupancy helper for the result readout stage.
package result_stream_pkg;

  localparam int unsigned ADDR_WIDTH_DEF   = 7;
  localparam int unsigned RESULT_WIDTH_DEF = 24;
  localparam int unsigned NUM_ENTRIES_DEF  = 128;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    CHECK = 2'd3
  } state_t;

  // Slots available by the next edge; a pop committed this cycle frees one.
  function automatic int unsigned fifo_free(input int unsigned depth,
                                            input int unsigned count,
                                            input logic        pop);
    return depth - count + (pop ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Dual-push, single-pop circular buffer; the writer guarantees it never overflows.
module result_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata_a,
  input  logic [WIDTH-1:0]         wdata_b,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count + (push ? CNT_W'(2) : CNT_W'(0)) - (pop ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr]               <= wdata_a;
        mem[wr_ptr + PTR_W'(1)]   <= wdata_b;
        wr_ptr                    <= wr_ptr + PTR_W'(2);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_d;
      valid <= (count_d != '0);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/result_stream_reader.sv
// Reads the result RAM in address pairs, streams words in order and checks their sum.
module result_stream_reader
  import result_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned RESULT_WIDTH = RESULT_WIDTH_DEF,
  parameter int unsigned NUM_ENTRIES  = NUM_ENTRIES_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   rd_addrA,
  output logic [ADDR_WIDTH-1:0]   rd_addrB,
  input  logic [RESULT_WIDTH-1:0] rd_dataA,
  input  logic [RESULT_WIDTH-1:0] rd_dataB,
  input  logic [RESULT_WIDTH-1:0] matrix_sum,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    sum_match
);

  localparam int unsigned NUM_PAIRS = NUM_ENTRIES / 2;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

  state_t                  state;
  state_t                  state_d;
  logic                    issue;
  logic                    done_d;
  logic                    issued;
  logic                    arriving;
  logic                    pop;
  logic                    can_issue;
  logic [ADDR_WIDTH-1:0]   pair_cnt;
  logic [ADDR_WIDTH-1:0]   issue_idx;
  logic [CNT_W-1:0]        fifo_count;
  logic [RESULT_WIDTH-1:0] checksum;
  int unsigned             in_flight;

  assign pop       = out_valid & out_ready;
  assign issue_idx = (state == IDLE) ? '0 : pair_cnt;

  // Words already requested from RAM but not yet counted in the FIFO.
  always_comb begin
    in_flight = (issued ? 32'd2 : 32'd0) + (arriving ? 32'd2 : 32'd0);
    can_issue = (fifo_free(FIFO_DEPTH, 32'(fifo_count), pop) >= in_flight + 32'd2);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          issue   = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (pair_cnt == ADDR_WIDTH'(NUM_PAIRS)) begin
          state_d = DRAIN;
        end else if (can_issue) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (!out_valid && !issued && !arriving) begin
          state_d = CHECK;
          done_d  = 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address issue, in-flight pipeline, status outputs and checksum.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      rd_addrA  <= '0;
      rd_addrB  <= '0;
      pair_cnt  <= '0;
      issued    <= 1'b0;
      arriving  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_match <= 1'b0;
      checksum  <= '0;
    end else begin
      issued   <= issue;
      arriving <= issued;
      busy     <= (state_d != IDLE);
      done     <= done_d;
      if (issue) begin
        rd_addrA <= ADDR_WIDTH'({issue_idx, 1'b0});
        rd_addrB <= ADDR_WIDTH'({issue_idx, 1'b1});
        pair_cnt <= issue_idx + ADDR_WIDTH'(1);
      end else if (state_d == IDLE) begin
        rd_addrA <= '0;
        rd_addrB <= '0;
      end
      if (state == IDLE && start) begin
        checksum  <= '0;
        sum_match <= 1'b0;
      end else if (pop) begin
        checksum <= checksum + out_data;
      end
      if (done_d) begin
        sum_match <= (checksum == matrix_sum);
      end
    end
  end

  result_fifo #(
    .WIDTH (RESULT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (reset),
    .push    (arriving),
    .wdata_a (rd_dataA),
    .wdata_b (rd_dataB),
    .pop     (pop),
    .rdata   (out_data),
    .valid   (out_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_result_stream_reader.sv
// Scoreboard bench: RAM model, random backpressure, in-order stream and checksum checks.
module tb_result_stream_reader;

  localparam int unsigned AW = 7;
  localparam int unsigned RW = 24;
  localparam int unsigned N  = 128;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] rd_addrA, rd_addrB;
  logic [RW-1:0] rd_dataA, rd_dataB;
  logic [RW-1:0] matrix_sum;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy, done, sum_match;

  logic [RW-1:0] mem [N];
  logic [RW-1:0] exp_q [$];
  logic          exp_match_q [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_seen = 0;
  int acc_cnt = 0;
  int first_valid_cyc = -1;
  int done_cyc = -1;
  int ready_pct = 100;
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  result_stream_reader #(
    .ADDR_WIDTH   (AW),
    .RESULT_WIDTH (RW),
    .NUM_ENTRIES  (N),
    .FIFO_DEPTH   (FD)
  ) u_dut (
    .CLOCK_50   (clk),
    .reset      (rst_n),
    .start      (start),
    .rd_addrA   (rd_addrA),
    .rd_addrB   (rd_addrB),
    .rd_dataA   (rd_dataA),
    .rd_dataB   (rd_dataB),
    .matrix_sum (matrix_sum),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .sum_match  (sum_match)
  );

  // Registered-read dual-port RAM model.
  always @(posedge clk) begin
    rd_dataA <= mem[rd_addrA];
    rd_dataB <= mem[rd_addrB];
    cyc      <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word and on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {7'd0, out_valid, out_data}, {7'd0, 1'b1, prev_data});
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word actual=%0h expected=none", out_data);
        end else begin
          check("word", out_data, exp_q.pop_front());
        end
        acc_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        if (exp_match_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_done actual=1 expected=0");
        end else begin
          check("sum_match", sum_match, exp_match_q.pop_front());
        end
      end
    end
  end

  // Backpressure generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_addrA"},  rd_addrA,  0);
    check({tag, "_rd_addrB"},  rd_addrB,  0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_sum_match"}, sum_match, 0);
  endtask

  // Fill RAM, compute the expected stream and compare result from first principles.
  task automatic prep(input int pct, input logic [RW-1:0] msum, input bit all_ones);
    logic [RW-1:0] s;
    s = '0;
    exp_q.delete();
    exp_match_q.delete();
    for (int i = 0; i < N; i++) begin
      mem[i] = all_ones ? {RW{1'b1}} : RW'(i + 1);
      exp_q.push_back(mem[i]);
      s = s + mem[i];
    end
    exp_match_q.push_back(s == msum);
    matrix_sum      = msum;
    ready_pct       = pct;
    done_seen       = 0;
    acc_cnt         = 0;
    first_valid_cyc = -1;
    done_cyc        = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input bit timing);
    for (int t = 0; t < 3000 && done_seen == 0; t++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_done_count"}, done_seen, 1);
    check({tag, "_words"}, acc_cnt, N);
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_addr_end"}, {rd_addrA, rd_addrB}, 0);
    if (timing) begin
      check({tag, "_first_valid"}, first_valid_cyc - start_cyc, 3);
      check({tag, "_done_lat"}, done_cyc - start_cyc, 3 + N + 1);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    matrix_sum = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    prep(100, 24'd8256, 1'b0);
    pulse_start();
    #1 check("busy_after_start", busy, 1);
    finish_run("match", 1'b1);

    prep(100, 24'd8255, 1'b0);
    pulse_start();
    finish_run("mismatch", 1'b1);

    prep(30, 24'd8256, 1'b0);
    pulse_start();
    finish_run("stall30", 1'b0);

    prep(100, 24'hFFFF80, 1'b1);
    pulse_start();
    finish_run("wrap", 1'b1);

    // Reset in the middle of a stream.
    prep(70, 24'd8256, 1'b0);
    pulse_start();
    for (int t = 0; t < 3000 && acc_cnt < 40; t++) @(posedge clk);
    check("mid_acc40", acc_cnt, 40);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (5) @(posedge clk);
    #1 check("midrst_no_done", done_seen, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    prep(100, 24'd8256, 1'b0);
    pulse_start();
    finish_run("after_rst", 1'b1);

    // Second start during READ must be ignored.
    prep(100, 24'd8256, 1'b0);
    pulse_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_run("restart", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
